// File: rtl/schedule_table_pkg.sv
// Shared definitions for the TDM schedule table: entry field layout,
// the empty-slot marker and the decoded entry record.
package schedule_table_pkg;

  localparam int ENTRY_BITS = 32;
  localparam int CFG_ADDR_W = 14;
  localparam int CFG_DATA_W = 32;

  localparam int ROUTE_LSB = 16;
  localparam int ROUTE_W   = 16;
  localparam int DMA_LSB   = 8;
  localparam int DMA_W     = 8;
  localparam int PKT_LSB   = 4;
  localparam int PKT_W     = 4;
  localparam int T2N_LSB   = 0;
  localparam int T2N_W     = 4;

  // dma_num value that marks a slot with no DMA transfer
  localparam logic [DMA_W-1:0] EMPTY_DMA = 8'hFF;

  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [DMA_W-1:0]   dma_num;
    logic [PKT_W-1:0]   pkt_len;
    logic [T2N_W-1:0]   t2n;
  } entry_t;

  function automatic entry_t entry_from_word(input logic [ENTRY_BITS-1:0] w);
    entry_t e;
    e.route   = w[ROUTE_LSB +: ROUTE_W];
    e.dma_num = w[DMA_LSB +: DMA_W];
    e.pkt_len = w[PKT_LSB +: PKT_W];
    e.t2n     = w[T2N_LSB +: T2N_W];
    return e;
  endfunction

  function automatic logic is_empty_slot(input entry_t e);
    return e.dma_num == EMPTY_DMA;
  endfunction

endpackage

// File: rtl/schedule_table_stbl_ram.sv
// Two-port table memory. Port A is the configuration read/write port,
// port B the schedule read-only port. Both reads are registered and see
// the contents before any write in the same cycle. The array itself is
// not reset; only the read registers are.
module stbl_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // port A write into the array
  always_ff @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  // port A registered read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               a_rdata <= '0;
    else if (a_en && !a_we)   a_rdata <= mem[a_addr];
  end

  // port B registered read; holds when not enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    b_rdata <= '0;
    else if (b_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/schedule_table.sv
// TDM schedule table: software fills the table through the configuration
// slave port, the TDM controller walks it slot by slot and receives the
// decoded entry fields one cycle after presenting the index.
import schedule_table_pkg::*;

module schedule_table #(
  parameter int STBL_IDX_WIDTH = 8,
  parameter int ENTRY_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CFG_ADDR_W-1:0]     config_addr,
  input  logic                      config_en,
  input  logic                      config_wr,
  input  logic [CFG_DATA_W-1:0]     config_wdata,
  input  logic                      sel,
  output logic [CFG_DATA_W-1:0]     config_slv_rdata,
  output logic                      config_slv_error,
  input  logic [STBL_IDX_WIDTH-1:0] stbl_idx,
  input  logic                      stbl_idx_en,
  input  logic                      period_boundary,
  output logic [T2N_W-1:0]          t2n,
  output logic [ROUTE_W-1:0]        route,
  output logic [DMA_W-1:0]          dma_num,
  output logic [PKT_W-1:0]          pkt_len,
  output logic                      dma_en,
  output logic                      period_start
);

  logic                   acc;
  logic                   in_range;
  logic                   cfg_wr_ok;
  logic                   cfg_rd_ok;
  logic [ENTRY_WIDTH-1:0] a_rdata;
  logic [ENTRY_WIDTH-1:0] b_rdata;
  logic                   cfg_rd_q;
  logic                   cfg_err_q;
  logic                   sched_vld_q;
  logic                   period_q;
  entry_t                 ent;

  assign acc       = sel && config_en;
  assign in_range  = (config_addr >> STBL_IDX_WIDTH) == '0;
  assign cfg_wr_ok = acc && in_range && config_wr;
  assign cfg_rd_ok = acc && in_range && !config_wr;

  stbl_ram #(
    .ADDR_W (STBL_IDX_WIDTH),
    .DATA_W (ENTRY_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .a_en    (cfg_wr_ok || cfg_rd_ok),
    .a_we    (cfg_wr_ok),
    .a_addr  (config_addr[STBL_IDX_WIDTH-1:0]),
    .a_wdata (config_wdata[ENTRY_WIDTH-1:0]),
    .a_rdata (a_rdata),
    .b_en    (stbl_idx_en),
    .b_addr  (stbl_idx),
    .b_rdata (b_rdata)
  );

  // access qualifiers aligned with the registered memory reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_rd_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      sched_vld_q <= 1'b0;
      period_q    <= 1'b0;
    end else begin
      cfg_rd_q    <= cfg_rd_ok;
      cfg_err_q   <= acc && !in_range;
      sched_vld_q <= stbl_idx_en;
      period_q    <= period_boundary;
    end
  end

  // writes and idle cycles return zero data; only a good read shows the entry
  assign config_slv_rdata = cfg_rd_q ? CFG_DATA_W'(a_rdata) : '0;
  assign config_slv_error = cfg_err_q;

  assign ent          = entry_from_word(ENTRY_BITS'(b_rdata));
  assign route        = ent.route;
  assign dma_num      = ent.dma_num;
  assign pkt_len      = ent.pkt_len;
  assign t2n          = ent.t2n;
  assign dma_en       = sched_vld_q && !is_empty_slot(ent);
  assign period_start = period_q;

endmodule
